// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, ALU op codes and issue FSM state type
package alu_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_MUL   = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_AND   = 4'b0100,
    OP_OR    = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_NOT   = 4'b0111,
    OP_SHL   = 4'b1000,
    OP_SHR   = 4'b1001,
    OP_ROL   = 4'b1010,
    OP_ROR   = 4'b1011,
    OP_SLT   = 4'b1100,
    OP_SEQ   = 4'b1101,
    OP_PASSA = 4'b1110,
    OP_PASSB = 4'b1111
  } alu_op_e;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t WB   = 2'd2;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x DW register file, two operand reads, host read, WB-over-load writes
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] rh_addr,
  output logic [DW-1:0] rh_data
);

  logic [DW-1:0] mem [NREG];

  // Reads are combinational, so an accept in the same cycle as a write sees the old value
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
  assign rh_data = mem[rh_addr];

  // Per-entry write; writeback takes priority over the host load on an index collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_addr == AW'(i)))
          mem[i] <= wb_data;
        else if (ld_en && (ld_addr == AW'(i)))
          mem[i] <= ld_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue stage: command accept, operand fetch, writeback and flags
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic          cmd_imm_en,
  input  logic [DW-1:0] cmd_imm,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  output logic          busy,
  output logic          done,
  output logic          carry_flag,
  output logic          zero_flag,
  output logic          dz_err
);

  state_t        state;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          accept;
  logic          div_zero;
  logic          wb_en;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;
  // alu_sel/alu_b double as the op and operand-B latches, so this is valid through WB
  assign div_zero  = (alu_sel == 4'(OP_DIV)) && (alu_b == '0);
  assign wb_en     = (state == WB) && !div_zero;

  alu_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (dst_q),
    .wb_data (alu_out),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ra_addr (cmd_srca),
    .ra_data (ra_data),
    .rb_addr (cmd_srcb),
    .rb_data (rb_data),
    .rh_addr (rd_addr),
    .rh_data (rd_data)
  );

  // Fixed three-cycle sequence: accept in IDLE, one EXEC cycle, one WB cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= WB;
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand latches drive the ALU directly and hold steady until the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      dst_q   <= '0;
    end else if (accept) begin
      alu_a   <= ra_data;
      alu_b   <= cmd_imm_en ? cmd_imm : rb_data;
      alu_sel <= cmd_op;
      dst_q   <= cmd_dst;
    end
  end

  // done is high for exactly the WB cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == EXEC);
  end

  // Status flags sampled in WB; a divide by zero suppresses the write and the zero update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      dz_err     <= 1'b0;
    end else if (state == WB) begin
      if (alu_sel == 4'(OP_ADD)) carry_flag <= alu_carry;
      if (div_zero) dz_err    <= 1'b1;
      else          zero_flag <= (alu_out == '0);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_srca, cmd_srcb;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry;
  logic        busy, done, carry_flag, zero_flag, dz_err;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy), .done(done), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .dz_err(dz_err)
  );

  // Behavioural combinational ALU
  always_comb begin
    {alu_carry, alu_out} = 17'h0;
    case (alu_sel)
      4'b0000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: alu_out = alu_a - alu_b;
      4'b0011: alu_out = (alu_b != 16'h0) ? alu_a / alu_b : 16'h0;
      default: alu_out = alu_a & alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding command
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_sel", alu_sel, e.op);
          chk("wb_a", alu_a, e.a);
          chk("wb_b", alu_b, e.b);
          chk("done_latency", cyc - e.cyc, 2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    rd_addr = a;
    #2;
    chk(name, rd_data, exp);
  endtask

  // ld_mode: 0 none, 1 host load to srca in the accept cycle, 2 host load to dst in the WB cycle
  task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sbi, input logic imm_en, input logic [15:0] imm,
                       input logic [15:0] ea, input logic [15:0] eb,
                       input int ld_mode, input logic [15:0] ld_v);
    int w;
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sbi;
    cmd_imm_en = imm_en; cmd_imm = imm; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 10) begin tick(); w++; end
    chk("issue_ready", cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    if (ld_mode == 1) begin ld_en = 1'b1; ld_addr = sa; ld_data = ld_v; end
    sb.push_back('{op, ea, eb, cyc});
    exp_done++;
    tick();
    cmd_valid = 1'b0; ld_en = 1'b0;
    chk("exec_sel", alu_sel, op);
    chk("exec_busy", busy, 1);
    tick();
    if (ld_mode == 2) begin ld_en = 1'b1; ld_addr = dst; ld_data = ld_v; end
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, last_acc, gap;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_dst = 3'd0; cmd_srca = 3'd0;
    cmd_srcb = 3'd0; cmd_imm_en = 1'b0; cmd_imm = 16'h0; ld_en = 1'b0; ld_addr = 3'd0;
    ld_data = 16'h0; rd_addr = 3'd0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // 1. reset state and loads
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_flags", {carry_flag, zero_flag, dz_err}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    for (int i = 0; i < 8; i++) rd_chk("rst_reg", 3'(i), 16'h0);
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    load(3'd3, 16'hFFFF);
    load(3'd4, 16'h0002);
    load(3'd7, 16'h1234);
    rd_chk("ld_r1", 3'd1, 16'h0005);

    // 2. add with carry out
    issue(4'b0000, 3'd5, 3'd3, 3'd4, 1'b0, 16'h0, 16'hFFFF, 16'h0002, 0, 16'h0);
    rd_chk("add_r5", 3'd5, 16'h0001);
    chk("add_carry", carry_flag, 1);
    chk("add_zero", zero_flag, 0);

    // 3. immediate subtract to zero; carry holds
    issue(4'b0001, 3'd6, 3'd1, 3'd2, 1'b1, 16'h0005, 16'h0005, 16'h0005, 0, 16'h0);
    rd_chk("sub_r6", 3'd6, 16'h0000);
    chk("sub_zero", zero_flag, 1);
    chk("sub_carry_hold", carry_flag, 1);

    // 4. divide by zero, then a later command keeps dz_err
    issue(4'b0011, 3'd7, 3'd1, 3'd0, 1'b0, 16'h0, 16'h0005, 16'h0000, 0, 16'h0);
    rd_chk("dz_r7", 3'd7, 16'h1234);
    chk("dz_err", dz_err, 1);
    chk("dz_zero_hold", zero_flag, 1);
    issue(4'b0000, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0005, 16'h0003, 0, 16'h0);
    rd_chk("add2_r5", 3'd5, 16'h0008);
    chk("add2_carry", carry_flag, 0);
    chk("add2_zero", zero_flag, 0);
    chk("dz_sticky", dz_err, 1);

    // 5a. valid held for 6 cycles: two accepts 3 cycles apart; second sees first result
    cmd_op = 4'b0000; cmd_dst = 3'd4; cmd_srca = 3'd4; cmd_srcb = 3'd2;
    cmd_imm_en = 1'b0; cmd_valid = 1'b1;
    acc = 0; last_acc = 0; gap = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) begin
        if (acc == 0) sb.push_back('{4'b0000, 16'h0002, 16'h0003, cyc});
        else          sb.push_back('{4'b0000, 16'h0005, 16'h0003, cyc});
        exp_done++;
        if (acc > 0) gap = i - last_acc;
        last_acc = i;
        acc++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("hs_accepts", acc, 2);
    chk("hs_gap", gap, 3);
    tick();
    rd_chk("hs_r4", 3'd4, 16'h0008);

    // 5b. host load to dst in WB loses to the writeback
    issue(4'b0000, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0005, 16'h0003, 2, 16'hAAAA);
    rd_chk("coll_r6", 3'd6, 16'h0008);

    // 5c. host load to srca in the accept cycle: operand is the old value
    issue(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0005, 16'h0003, 1, 16'h0100);
    rd_chk("old_r3", 3'd3, 16'h0008);
    rd_chk("old_r1", 3'd1, 16'h0100);

    // 6. reset during EXEC aborts the command
    cmd_op = 4'b0000; cmd_dst = 3'd2; cmd_srca = 3'd1; cmd_srcb = 3'd1;
    cmd_imm_en = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) rd_chk("mid_reg", 3'(i), 16'h0);
    chk("mid_flags", {carry_flag, zero_flag, dz_err}, 0);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);
    chk("done_count", done_cnt, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
